// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-side bus of the memory access controller.
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32
);
   // Requester side (from MAR/MDR and the control unit)
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   // RAM side
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_complete;

   // Controller end: serves requests, drives the RAM strobes
   modport master (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_complete,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   // Environment end: requester plus RAM
   modport slave (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_complete,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the synchronous RAM.
`timescale 1ns/1ps
module mem_access_ctrl #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic               clck,
   input logic               clr_n,
   mem_access_ctrl_if.master bus
);
   localparam int unsigned REQ_W = 32;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              ready_q, ready_d;
   logic              rv_q, rv_d;
   logic              err_q, err_d;
   logic              oob;

   // Address bits above the RAM depth mark an out-of-range access
   assign oob = |bus.req_addr[REQ_W-1:ADDR_W];

   // Next state plus next value of every registered output
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      rv_d    = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr[ADDR_W-1:0];
               wdata_d = bus.req_wdata;
               cnt_d   = '0;
               if (oob) begin
                  state_d = RESP;
                  rv_d    = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Completion beats a simultaneous timeout
            if (bus.mem_complete) begin
               if (!we_q) rdata_d = bus.mem_rdata;
               state_d = RESP;
               rv_d    = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = RESP;
               rv_d    = 1'b1;
               err_d   = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Strobes follow the upcoming state so they register high only in ACCESS
      rd_d    = (state_d == ACCESS) && !we_d;
      wr_d    = (state_d == ACCESS) && we_d;
      ready_d = (state_d == IDLE);
   end

   // State and output registers; reset drops any live strobe immediately
   always_ff @(posedge clck or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ready_q <= 1'b1;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = rv_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.mem_read   = rd_q;
   assign bus.mem_write  = wr_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM stub, transaction-schedule model, per-cycle compare.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned DEPTH   = 512;

   logic clck  = 1'b0;
   logic clr_n = 1'b0;
   always #5 clck = ~clck;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clck (clck),
      .clr_n(clr_n),
      .bus  (bus)
   );

   // RAM stub: completes in the strobe cycle unless stalled
   logic              stall     = 1'b0;
   logic              force_cmp = 1'b0;
   logic [DATA_W-1:0] ram [0:DEPTH-1] = '{default: '0};
   assign bus.mem_complete = ((bus.mem_read | bus.mem_write) & ~stall) | force_cmp;
   assign bus.mem_rdata    = ram[bus.mem_addr];
   always @(posedge clck)
      if (bus.mem_write && bus.mem_complete) ram[bus.mem_addr] <= bus.mem_wdata;

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b want %0b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Model: each accepted request books a schedule of strobe, response and ready cycles
   int                cyc = 0;
   int                rdy_cyc = 0, s0 = 1, s1 = 0, r_cyc = -1;
   logic              m_we = 1'b0, m_err = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0, r_rdata = '0, exp_rdata = '0;
   logic [DATA_W-1:0] ram_m [0:DEPTH-1] = '{default: '0};

   function automatic int dur(input logic [31:0] a, input logic st);
      if (a >= DEPTH) return 0;
      return st ? int'(TIMEOUT) : 1;
   endfunction

   always @(posedge clck) cyc <= cyc + 1;

   always @(posedge clck or negedge clr_n) begin
      if (!clr_n) begin
         rdy_cyc   <= 0;
         s0        <= 1;
         s1        <= 0;
         r_cyc     <= -1;
         exp_rdata <= '0;
      end else begin
         if (cyc + 1 == r_cyc) exp_rdata <= r_rdata;
         if (bus.req_valid && cyc >= rdy_cyc) begin
            s0      <= cyc + 1;
            s1      <= cyc + dur(bus.req_addr, stall);
            r_cyc   <= cyc + 1 + dur(bus.req_addr, stall);
            rdy_cyc <= cyc + 2 + dur(bus.req_addr, stall);
            m_we    <= bus.req_we;
            m_addr  <= bus.req_addr[ADDR_W-1:0];
            m_wdata <= bus.req_wdata;
            m_err   <= (bus.req_addr >= DEPTH) || stall;
            if (bus.req_addr < DEPTH && !stall && !bus.req_we)
               r_rdata <= ram_m[bus.req_addr[ADDR_W-1:0]];
            else
               r_rdata <= exp_rdata;
            if (bus.req_addr < DEPTH && !stall && bus.req_we)
               ram_m[bus.req_addr[ADDR_W-1:0]] <= bus.req_wdata;
         end
      end
   end

   // Per-cycle compare of every output against the model schedule
   always @(negedge clck) begin
      if (clr_n) begin
         chk1("req_ready", bus.req_ready, cyc >= rdy_cyc);
         chk1("mem_read", bus.mem_read, (cyc >= s0) && (cyc <= s1) && !m_we);
         chk1("mem_write", bus.mem_write, (cyc >= s0) && (cyc <= s1) && m_we);
         if (cyc >= s0 && cyc <= s1) begin
            chk32("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk32("mem_wdata", bus.mem_wdata, m_wdata);
         end
         chk1("resp_valid", bus.resp_valid, cyc == r_cyc);
         if (cyc == r_cyc) chk1("resp_err", bus.resp_err, m_err);
         chk32("resp_rdata", bus.resp_rdata, exp_rdata);
      end
   end

   // Present a request and hold it until the model says it was taken
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int t);
      bit acc = 1'b0;
      t = cyc;
      @(negedge clck);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (cyc >= rdy_cyc) begin
            t   = cyc + 1;
            acc = 1'b1;
         end
         @(negedge clck);
      end
      bus.req_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept: request not taken within 50 cycles");
      end
   endtask

   // Watch from the first post-accept cycle until the response pulse
   task automatic wait_resp(input int t, output int lat, output int nstb,
                            output logic err, output logic [31:0] rd);
      bit got = 1'b0;
      lat = -1; nstb = 0; err = 1'b0; rd = '0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (bus.mem_read || bus.mem_write) nstb++;
         if (bus.resp_valid) begin
            got = 1'b1;
            lat = cyc - (t - 1);
            err = bus.resp_err;
            rd  = bus.resp_rdata;
         end else begin
            @(negedge clck);
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL resp: no resp_valid within 40 cycles");
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output int nstb, output logic err, output logic [31:0] rd);
      int t;
      send(we, addr, wd, t);
      wait_resp(t, lat, nstb, err, rd);
   endtask

   initial begin
      int          lat, nstb, t;
      logic        err;
      logic [31:0] rd;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Outputs while held in reset
      #3;
      chk1("rst mem_read", bus.mem_read, 1'b0);
      chk1("rst mem_write", bus.mem_write, 1'b0);
      chk32("rst mem_addr", 32'(bus.mem_addr), 32'd0);
      chk32("rst mem_wdata", bus.mem_wdata, 32'd0);
      chk1("rst resp_valid", bus.resp_valid, 1'b0);
      chk32("rst resp_rdata", bus.resp_rdata, 32'd0);
      chk1("rst resp_err", bus.resp_err, 1'b0);
      repeat (2) @(negedge clck);
      clr_n = 1'b1;
      @(negedge clck);
      chk1("ready after reset", bus.req_ready, 1'b1);

      // Load from cleared RAM
      txn(1'b0, 32'd0, 32'd0, lat, nstb, err, rd);
      chki("ld0 latency", lat, 2);
      chki("ld0 strobes", nstb, 1);
      chk1("ld0 err", err, 1'b0);
      chk32("ld0 data", rd, 32'd0);

      // Store then load address 0
      txn(1'b1, 32'd0, 32'd86, lat, nstb, err, rd);
      chki("st0 latency", lat, 2);
      chk1("st0 err", err, 1'b0);
      txn(1'b0, 32'd0, 32'd0, lat, nstb, err, rd);
      chk32("ld0 after st", rd, 32'd86);

      // Top address, no wrap
      txn(1'b1, 32'd511, 32'd2, lat, nstb, err, rd);
      txn(1'b0, 32'd511, 32'd0, lat, nstb, err, rd);
      chk32("ld511 data", rd, 32'd2);
      chk1("ld511 err", err, 1'b0);

      // Out of range: no strobe, error after one cycle, data held
      txn(1'b0, 32'd512, 32'd0, lat, nstb, err, rd);
      chki("oob latency", lat, 1);
      chki("oob strobes", nstb, 0);
      chk1("oob err", err, 1'b1);
      chk32("oob data held", rd, 32'd2);
      txn(1'b1, 32'h8000_0000, 32'hdead, lat, nstb, err, rd);
      chk1("oob high err", err, 1'b1);

      // Stray completion while idle must be ignored
      @(negedge clck);
      force_cmp = 1'b1;
      repeat (3) @(negedge clck);
      force_cmp = 1'b0;

      // Stuck RAM: strobe held TIMEOUT cycles, then error; next access recovers
      stall = 1'b1;
      txn(1'b0, 32'd3, 32'd0, lat, nstb, err, rd);
      stall = 1'b0;
      chki("tmo strobes", nstb, 16);
      chki("tmo latency", lat, 17);
      chk1("tmo err", err, 1'b1);
      chk32("tmo data held", rd, 32'd2);
      txn(1'b0, 32'd0, 32'd0, lat, nstb, err, rd);
      chk32("after tmo data", rd, 32'd86);
      chk1("after tmo err", err, 1'b0);

      // Reset in the middle of a stalled store
      stall = 1'b1;
      send(1'b1, 32'd0, 32'h55, t);
      repeat (3) @(negedge clck);
      chk1("store strobe live", bus.mem_write, 1'b1);
      #2 clr_n = 1'b0;
      #1;
      chk1("rst drops write", bus.mem_write, 1'b0);
      chk1("rst no resp", bus.resp_valid, 1'b0);
      stall = 1'b0;
      repeat (2) @(negedge clck);
      clr_n = 1'b1;
      repeat (3) @(negedge clck);
      txn(1'b0, 32'd0, 32'd0, lat, nstb, err, rd);
      chk32("ld after rst", rd, 32'd86);
      txn(1'b1, 32'd1, 32'hab, lat, nstb, err, rd);
      txn(1'b0, 32'd1, 32'd0, lat, nstb, err, rd);
      chk32("ld1 data", rd, 32'hab);
      repeat (3) @(negedge clck);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop if something wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
